// File: rtl/module_alu_seq.sv
// module_alu_seq: multi-cycle sequencer in front of the shared 16-bit ALU.
// ADD/SUB take one ALU pass. MUL (shift-add) and DIV (restoring) take ITER
// iterations, each of which is a single ALU ADD or SUB.
// Optional macro ALU_SEQ_SIGNED_EN: MUL/DIV treat operands as two's complement.
module module_alu_seq #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_cmd,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0] rsp_aux,
    output logic             rsp_err,
    output logic             busy,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    input  logic [WIDTH-1:0] alu_result
);
    localparam int CW = $clog2(ITER);
    localparam logic [1:0] C_ADD = 2'b00, C_SUB = 2'b01, C_MUL = 2'b10, C_DIV = 2'b11;
    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001;

    typedef enum logic [2:0] {IDLE, EXEC, MUL_IT, DIV_IT, DONE} state_t;

    state_t           state_q;
    logic [1:0]       cmd_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] acc_q, lo_q;     // MUL: {acc,lo}; DIV: rem=acc, quotient=lo
    logic [WIDTH-1:0] acc_d, lo_d;
    logic [CW-1:0]    cnt_q;
    logic             rsp_valid_q, rsp_err_q;
    logic [WIDTH-1:0] rsp_result_q, rsp_aux_q;
    logic [WIDTH:0]   sh;
    logic             carry, take;
    logic [WIDTH-1:0] a_ld, b_ld;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fin_res, fin_aux;
`ifdef ALU_SEQ_SIGNED_EN
    logic             neg_q, sa_q;     // result sign, dividend sign
`endif

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_aux    = rsp_aux_q;
    assign rsp_err    = rsp_err_q;

    // Operand load values: MUL/DIV iterate on magnitudes when signed mode is on
    always_comb begin
        a_ld = req_a;
        b_ld = req_b;
`ifdef ALU_SEQ_SIGNED_EN
        if (req_cmd[1]) begin
            if (req_a[WIDTH-1]) a_ld = -req_a;
            if (req_b[WIDTH-1]) b_ld = -req_b;
        end
`endif
    end

    // ALU drive decoded from state; idle ALU sees all zeros
    always_comb begin
        alu_op  = '0;
        alu_in1 = '0;
        alu_in2 = '0;
        sh      = {acc_q, lo_q[WIDTH-1]};
        case (state_q)
            EXEC: if (cmd_q != C_DIV) begin
                alu_op  = (cmd_q == C_SUB) ? OP_SUB : OP_ADD;
                alu_in1 = a_q;
                alu_in2 = b_q;
            end
            MUL_IT: begin
                alu_op  = OP_ADD;
                alu_in1 = acc_q;
                alu_in2 = b_q;
            end
            DIV_IT: begin
                alu_op  = OP_SUB;
                alu_in1 = sh[WIDTH-1:0];
                alu_in2 = b_q;
            end
            default: ;
        endcase
    end

    // One shift-add or restoring-divide step, plus the final result shaping
    always_comb begin
        acc_d = acc_q;
        lo_d  = lo_q;
        carry = (alu_result < acc_q);
        take  = sh[WIDTH] | (sh[WIDTH-1:0] >= b_q);
        if (state_q == MUL_IT) begin
            if (lo_q[0]) begin
                acc_d = {carry, alu_result[WIDTH-1:1]};
                lo_d  = {alu_result[0], lo_q[WIDTH-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[WIDTH-1:1]};
                lo_d  = {acc_q[0], lo_q[WIDTH-1:1]};
            end
        end else if (state_q == DIV_IT) begin
            lo_d  = {lo_q[WIDTH-2:0], take};
            acc_d = take ? alu_result : sh[WIDTH-1:0];
        end
        prod    = {acc_d, lo_d};
        fin_res = lo_d;
        fin_aux = acc_d;
`ifdef ALU_SEQ_SIGNED_EN
        if (neg_q) prod = -prod;
        if (neg_q) fin_res = -lo_d;
        if (sa_q)  fin_aux = -acc_d;
`endif
        if (state_q == MUL_IT) begin
            fin_res = prod[WIDTH-1:0];
            fin_aux = prod[2*WIDTH-1:WIDTH];
        end
    end

    // Sequencer FSM with registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            lo_q         <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_aux_q    <= '0;
            rsp_err_q    <= 1'b0;
`ifdef ALU_SEQ_SIGNED_EN
            neg_q        <= 1'b0;
            sa_q         <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    cmd_q <= req_cmd;
                    a_q   <= req_a;
                    b_q   <= b_ld;
                    acc_q <= '0;
                    lo_q  <= a_ld;
                    cnt_q <= '0;
`ifdef ALU_SEQ_SIGNED_EN
                    neg_q <= req_a[WIDTH-1] ^ req_b[WIDTH-1];
                    sa_q  <= req_a[WIDTH-1];
`endif
                    if (req_cmd == C_MUL)                         state_q <= MUL_IT;
                    else if (req_cmd == C_DIV && req_b != '0)     state_q <= DIV_IT;
                    else                                          state_q <= EXEC;
                end
                EXEC: begin
                    rsp_valid_q <= 1'b1;
                    if (cmd_q == C_DIV) begin
                        rsp_result_q <= '1;
                        rsp_aux_q    <= a_q;
                        rsp_err_q    <= 1'b1;
                    end else begin
                        rsp_result_q <= alu_result;
                        rsp_aux_q    <= '0;
                        rsp_err_q    <= 1'b0;
                    end
                    state_q <= DONE;
                end
                MUL_IT, DIV_IT: begin
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER-1)) begin
                        cnt_q        <= '0;
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= fin_res;
                        rsp_aux_q    <= fin_aux;
                        rsp_err_q    <= 1'b0;
                        state_q      <= DONE;
                    end
                end
                DONE: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_module_alu_seq.sv
// Bench for module_alu_seq: table of directed vectors, random vectors against
// a behavioural model, response back-pressure and mid-operation reset.
module tb_module_alu_seq;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0;
    logic [1:0]  req_cmd = '0;
    logic [15:0] req_a = '0, req_b = '0, rsp_result, rsp_aux;
    logic        rsp_err, busy;
    logic [3:0]  alu_op;
    logic [15:0] alu_in1, alu_in2, alu_result;

    int checks = 0, errors = 0;

    typedef struct packed {logic [15:0] res; logic [15:0] aux; logic err;} exp_t;
    typedef struct {logic [1:0] cmd; logic [15:0] a, b, res, aux; logic err; int lat;} vec_t;

    exp_t sb[$];
    vec_t vt[$];

    always #5 clk = ~clk;

    // Shared ALU stand-in
    assign alu_result = (alu_op == 4'b0000) ? alu_in1 + alu_in2 :
                        (alu_op == 4'b0001) ? alu_in1 - alu_in2 : 16'h0000;

    module_alu_seq dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_aux(rsp_aux),
        .rsp_err(rsp_err), .busy(busy), .alu_op(alu_op), .alu_in1(alu_in1),
        .alu_in2(alu_in2), .alu_result(alu_result)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] cmd, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        logic [31:0] p;
        e.err = 1'b0;
        e.aux = 16'h0;
        case (cmd)
            2'b00: e.res = a + b;
            2'b01: e.res = a - b;
            2'b10: begin
`ifdef ALU_SEQ_SIGNED_EN
                p = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
`else
                p = {16'h0, a} * {16'h0, b};
`endif
                e.res = p[15:0];
                e.aux = p[31:16];
            end
            default: begin
                if (b == 16'h0) begin
                    e.res = 16'hFFFF; e.aux = a; e.err = 1'b1;
                end else begin
`ifdef ALU_SEQ_SIGNED_EN
                    if (a == 16'h8000 && b == 16'hFFFF) begin
                        e.res = 16'h8000; e.aux = 16'h0;
                    end else begin
                        e.res = $signed(a) / $signed(b);
                        e.aux = $signed(a) % $signed(b);
                    end
`else
                    e.res = a / b;
                    e.aux = a % b;
`endif
                end
            end
        endcase
        return e;
    endfunction

    function automatic int lat_of(input logic [1:0] cmd, input logic [15:0] b);
        return (cmd[1] && !(cmd == 2'b11 && b == 16'h0)) ? 17 : 2;
    endfunction

    // Drive one command, push its expectation at the accept edge
    task automatic send(input logic [1:0] cmd, input logic [15:0] a, input logic [15:0] b,
                        input exp_t e);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk("req_ready_wait", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_cmd = cmd; req_a = a; req_b = b;
        @(posedge clk);
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'h1, 32'h0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_result"}, {16'h0, rsp_result}, {16'h0, e.res});
            chk({tag, "_aux"}, {16'h0, rsp_aux}, {16'h0, e.aux});
            chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, e.err});
        end
    endtask

    // Called at the negedge after accept: checks ALU op, latency, response, handshake
    task automatic collect(input string tag, input int lat, input logic [3:0] op, input logic div0);
        int n = 1;
        chk({tag, "_alu_op"}, {28'h0, alu_op}, {28'h0, op});
        if (div0) chk({tag, "_alu_in"}, {alu_in1, alu_in2}, 32'h0);
        while (!rsp_valid && n < 40) begin @(posedge clk); n++; @(negedge clk); end
        chk({tag, "_latency"}, n, lat);
        pop_cmp(tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_idle_after"}, {30'h0, req_ready, rsp_valid}, 32'h2);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        exp_t e;
        logic [3:0] op;
        e.res = v.res; e.aux = v.aux; e.err = v.err;
        op = (v.cmd == 2'b01 || (v.cmd == 2'b11 && v.b != 16'h0)) ? 4'b0001 : 4'b0000;
        send(v.cmd, v.a, v.b, e);
        collect(tag, v.lat, op, (v.cmd == 2'b11 && v.b == 16'h0));
    endtask

    function automatic vec_t mk(input logic [1:0] c, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] r, input logic [15:0] x, input logic e, input int l);
        vec_t v;
        v.cmd = c; v.a = a; v.b = b; v.res = r; v.aux = x; v.err = e; v.lat = l;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        vec_t v;
        int n;
        logic [15:0] held;

        vt.push_back(mk(2'b00, 16'h1234, 16'h0FFF, 16'h2233, 16'h0000, 1'b0, 2));
        vt.push_back(mk(2'b01, 16'h0001, 16'h0002, 16'hFFFF, 16'h0000, 1'b0, 2));
        vt.push_back(mk(2'b00, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 2));
        vt.push_back(mk(2'b11, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 2));
        vt.push_back(mk(2'b11, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 17));
        vt.push_back(mk(2'b11, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17));
`ifdef ALU_SEQ_SIGNED_EN
        vt.push_back(mk(2'b10, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17));
        vt.push_back(mk(2'b10, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF, 1'b0, 17));
        vt.push_back(mk(2'b11, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 17));
        vt.push_back(mk(2'b11, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 17));
`else
        vt.push_back(mk(2'b10, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 17));
        vt.push_back(mk(2'b10, 16'hFFFD, 16'h0005, 16'hFFF1, 16'h0004, 1'b0, 17));
        vt.push_back(mk(2'b11, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 17));
        vt.push_back(mk(2'b11, 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 1'b0, 17));
`endif

        // Reset state
        #12;
        chk("rst_outputs", {rsp_valid, rsp_err, busy, req_ready, alu_op}, {4'b0001, 4'h0});
        chk("rst_data", {rsp_result, rsp_aux}, 32'h0);
        chk("rst_alu_in", {alu_in1, alu_in2}, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < vt.size(); i++) run_vec($sformatf("vec%0d", i), vt[i]);

        // Random vectors against the model
        for (int i = 0; i < 16; i++) begin
            v.cmd = 2'($urandom_range(0, 3));
            v.a   = 16'($urandom);
            v.b   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 9)) : 16'($urandom);
            e     = model(v.cmd, v.a, v.b);
            v.res = e.res; v.aux = e.aux; v.err = e.err; v.lat = lat_of(v.cmd, v.b);
            run_vec($sformatf("rnd%0d", i), v);
        end

        // Back-pressure: response held, second command waits for the handshake
        send(2'b10, 16'h0003, 16'h0005, model(2'b10, 16'h0003, 16'h0005));
        n = 1;
        while (!rsp_valid && n < 40) begin @(posedge clk); n++; @(negedge clk); end
        chk("hold_latency", n, 17);
        held = rsp_result;
        req_valid = 1'b1; req_cmd = 2'b00; req_a = 16'h0010; req_b = 16'h0020;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("hold_stable%0d", i), {15'h0, rsp_valid, req_ready, rsp_result},
                {15'h0, 1'b1, 1'b0, held});
        end
        pop_cmp("hold");
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hold_ready_next", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        sb.push_back(model(2'b00, 16'h0010, 16'h0020));
        @(negedge clk);
        req_valid = 1'b0;
        chk("hold_second_busy", {31'h0, busy}, 32'h1);
        collect("hold2", 2, 4'b0000, 1'b0);

        // Reset during MUL iteration
        send(2'b10, 16'hFFFF, 16'hFFFF, model(2'b10, 16'hFFFF, 16'hFFFF));
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outputs", {rsp_valid, rsp_err, busy, req_ready, alu_op}, {4'b0001, 4'h0});
        chk("arst_data", {rsp_result, rsp_aux}, 32'h0);
        chk("arst_alu_in", {alu_in1, alu_in2}, 32'h0);
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (rsp_valid) n++; end
        chk("arst_no_rsp", n, 0);
        run_vec("post_rst_add", mk(2'b00, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 1'b0, 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
